// File: rtl/aabb_hit_resolver_pkg.sv
// Shared ray-tracing types for the hit resolver: fixed-point, primitive index,
// hit record and the resolver FSM state encoding.
package aabb_hit_resolver_pkg;

  // Signed 16.16 fixed point
  typedef logic signed [31:0] Fixed;

  typedef logic [15:0] PRIMITIVE_INDEX;
  localparam PRIMITIVE_INDEX NULL_PRIMITIVE_INDEX = 16'hFFFF;

  typedef struct packed {
    Fixed x;
    Fixed y;
    Fixed z;
  } Vec3;

  typedef struct packed {
    logic           bHit;
    Fixed           T;
    Vec3            Normal;
    logic [23:0]    Color;
    PRIMITIVE_INDEX PI;
    logic [1:0]     SurfaceType;
  } HitData;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } HitResolveState;

  function automatic HitData miss_hit();
    HitData h;
    h    = '0;
    h.PI = NULL_PRIMITIVE_INDEX;
    return h;
  endfunction

endpackage

// File: rtl/aabb_hit_resolver_hit_closer.sv
// Replace decision: a hitting candidate wins over a missing best or a strictly
// farther best; equal distances keep the earlier candidate.
module hit_closer
  import aabb_hit_resolver_pkg::*;
(
  input  HitData cand,
  input  HitData best,
  output logic   replace
);

  // Signed distance compare gated by the hit flags
  always_comb begin
    replace = 1'b0;
    if (cand.bHit) begin
      if (!best.bHit) begin
        replace = 1'b1;
      end else if ($signed(cand.T) < $signed(best.T)) begin
        replace = 1'b1;
      end else begin
        replace = 1'b0;
      end
    end else begin
      replace = 1'b0;
    end
  end

endmodule

// File: rtl/aabb_hit_resolver.sv
// Reduces a stream of per-primitive candidates for one ray to the closest hit
// (or the first hit in any-hit mode) and presents it with tag and beat count.
module aabb_hit_resolver
  import aabb_hit_resolver_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  HitData           in_hit,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_any_hit,
  output logic             out_valid,
  input  logic             out_ready,
  output HitData           out_hit,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] out_count,
  output logic             err
);

  HitResolveState   state_q, state_d;
  HitData           best_q, best_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             any_q, any_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             xfer_in;
  logic             replace;
  logic [CNT_W-1:0] count_inc;

  hit_closer u_hit_closer (
    .cand    (in_hit),
    .best    (best_q),
    .replace (replace)
  );

  assign xfer_in   = in_valid && (state_q != OUT);
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : (count_q + CNT_W'(1));

  // Next-state and datapath update for accepted beats and output handshake
  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    tag_d   = tag_q;
    any_d   = any_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE, ACCUM, DRAIN: begin
        if (xfer_in) begin
          if (in_first) begin
            // A first beat mid-ray abandons the unfinished ray
            err_d   = err_q | (state_q != IDLE);
            best_d  = in_hit.bHit ? in_hit : miss_hit();
            tag_d   = in_tag;
            any_d   = in_any_hit;
            count_d = CNT_W'(1);
            if (in_last) begin
              state_d = OUT;
            end else if (in_any_hit && in_hit.bHit) begin
              state_d = DRAIN;
            end else begin
              state_d = ACCUM;
            end
          end else if (state_q == IDLE) begin
            err_d = 1'b1;
          end else begin
            count_d = count_inc;
            if ((state_q == ACCUM) && replace) begin
              best_d = in_hit;
            end else begin
              best_d = best_q;
            end
            if (in_last) begin
              state_d = OUT;
            end else if ((state_q == ACCUM) && any_q && in_hit.bHit) begin
              state_d = DRAIN;
            end else begin
              state_d = state_q;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      best_q  <= miss_hit();
      tag_q   <= {TAG_W{1'b0}};
      any_q   <= 1'b0;
      count_q <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      tag_q   <= tag_d;
      any_q   <= any_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q != OUT);
  assign out_valid = (state_q == OUT);
  assign out_hit   = best_q;
  assign out_tag   = tag_q;
  assign out_count = count_q;
  assign err       = err_q;

endmodule
